// File: rtl/cpu_pkg.sv
// Types and constants shared between the fetch queue and the PC generator.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC00000;
  localparam int FETCH_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched instructions tagged with their address.
// The head reads as zero while the FIFO is empty.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues sequential memory reads, queues the
// in-order responses with their addresses and drops stale ones after a redirect.
module instr_fetch_queue #(
  parameter int          DEPTH    = cpu_pkg::FETCH_DEPTH,
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
);

  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] count;
  logic [CW-1:0] in_use;
  logic          fifo_full;
  logic          fifo_empty;
  logic          req_fire;
  logic          resp_keep;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Every in-flight request owns a queue slot, so a response can always be stored.
  assign in_use         = outstanding + count;
  assign imem_req_valid = rst && !flush && (in_use < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_keep   = imem_resp_valid && (drop_cnt == '0) && !flush;
  assign push        = resp_keep && (!fifo_full || pop);
  assign push_entry  = '{pc: resp_pc, instr: imem_resp_data};
  assign instr_valid = !fifo_empty && !flush;
  assign pop         = instr_valid && instr_ready;
  assign instr_out   = head.instr;
  assign instr_pc    = head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // On a redirect, all requests still in flight become stale and are counted into drop_cnt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (flush) begin
      fetch_pc    <= flush_pc;
      resp_pc     <= flush_pc;
      outstanding <= outstanding - CW'(imem_resp_valid);
      drop_cnt    <= outstanding - CW'(imem_resp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
      if (imem_resp_valid) begin
        if (drop_cnt != '0) begin
          drop_cnt <= drop_cnt - CW'(1);
        end else begin
          resp_pc <= resp_pc + 32'd4;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with an in-order memory model and a
// scoreboard that expects sequential instruction addresses.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mem_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          lat;
  int          req_total;
  int          pops;
  int          pops_start;
  logic [31:0] exp_pc;
  logic [31:0] exp_req_addr;
  logic [31:0] last_req_addr;

  always #5 clk = ~clk;

  instr_fetch_queue dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
    end
  endtask

  // Records the handshakes of the current cycle, advances one clock and
  // drives the memory response for the new cycle.
  task automatic tick();
    #1;
    if (imem_req_valid && imem_req_ready) begin
      check_output("req_addr", imem_req_addr, exp_req_addr);
      exp_req_addr  = exp_req_addr + 32'd4;
      last_req_addr = imem_req_addr;
      mem_q.push_back('{imem_req_addr, cyc + lat});
      req_total++;
    end
    if (instr_valid && instr_ready) begin
      check_output("pop_pc", instr_pc, exp_pc);
      check_output("pop_instr", instr_out, exp_pc ^ 32'hFFFF_FFFF);
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (flush) begin
      exp_pc       = flush_pc;
      exp_req_addr = flush_pc;
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_q[0].addr ^ 32'hFFFF_FFFF;
      mem_q.delete(0);
    end
    if (imem_resp_valid) begin
      check_output("proto_outstanding", 32'(dut.outstanding != '0), 32'd1);
    end
  endtask

  task automatic apply_reset();
    rst             = 1'b0;
    flush           = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    mem_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst           = 1'b1;
    cyc           = 0;
    exp_pc        = 32'hBFC0_0000;
    exp_req_addr  = 32'hBFC0_0000;
    last_req_addr = 32'h0;
    req_total     = 0;
    pops          = 0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst             = 1'b0;
    flush           = 1'b0;
    flush_pc        = 32'h0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    instr_ready     = 1'b1;
    lat             = 1;

    // Reset values, then streaming with a 1-cycle memory
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_output("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_output("rst_instr_out", instr_out, 32'h0);
    check_output("rst_instr_pc", instr_pc, 32'h0);
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      #1;
      if (i < 2) begin
        check_output("lat_instr_valid_low", 32'(instr_valid), 32'd0);
      end else begin
        check_output("stream_instr_valid", 32'(instr_valid), 32'd1);
      end
      if (i == 2) begin
        check_output("first_instr_pc", instr_pc, 32'hBFC0_0000);
        check_output("first_instr_out", instr_out, 32'h403F_FFFF);
      end
      tick();
    end

    // Decode stall fills the queue and cuts off requests
    instr_ready = 1'b0;
    apply_reset();
    repeat (8) tick();
    #1;
    check_output("stall_req_total", 32'(req_total), 32'd4);
    check_output("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check_output("stall_instr_valid", 32'(instr_valid), 32'd1);
    check_output("stall_head_pc", instr_pc, 32'hBFC0_0000);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    repeat (5) tick();
    #1;
    check_output("unstall_req_total", 32'(req_total), 32'd5);
    check_output("unstall_req_addr", last_req_addr, 32'hBFC0_0010);
    check_output("unstall_req_valid", 32'(imem_req_valid), 32'd0);

    // Flush with three requests in flight on a 3-cycle memory
    instr_ready = 1'b1;
    lat         = 3;
    apply_reset();
    repeat (3) tick();
    flush    = 1'b1;
    flush_pc = 32'h0000_0100;
    #1;
    check_output("flush_req_valid", 32'(imem_req_valid), 32'd0);
    check_output("flush_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    flush = 1'b0;
    while (cyc < 10) begin
      #1;
      if (cyc == 4) check_output("refetch_addr", imem_req_addr, 32'h0000_0100);
      if (cyc < 8) check_output("stale_instr_valid", 32'(instr_valid), 32'd0);
      if (cyc == 8) check_output("redirect_pc0", instr_pc, 32'h0000_0100);
      if (cyc == 9) check_output("redirect_pc1", instr_pc, 32'h0000_0104);
      tick();
    end

    // Flush coinciding with a response and a decode pop
    lat = 2;
    apply_reset();
    repeat (6) tick();
    flush    = 1'b1;
    flush_pc = 32'h0000_0200;
    #1;
    check_output("flush2_instr_valid", 32'(instr_valid), 32'd0);
    check_output("flush2_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check_output("flush2_drop_cnt", 32'(dut.drop_cnt), 32'd1);
    check_output("flush2_queue_empty", 32'(instr_valid), 32'd0);
    check_output("flush2_req_addr", imem_req_addr, 32'h0000_0200);
    while (cyc < 11) begin
      #1;
      if (cyc < 10) check_output("flush2_wait_valid", 32'(instr_valid), 32'd0);
      if (cyc == 10) check_output("flush2_first_pc", instr_pc, 32'h0000_0200);
      tick();
    end

    // Random memory and decode backpressure against the scoreboard
    pops_start = pops;
    for (int i = 0; i < 200; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      instr_ready    = ($urandom_range(0, 3) != 0);
      tick();
    end
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    #1;
    check_output("bp_progress", 32'((pops - pops_start) >= 40), 32'd1);

    // Asynchronous reset with two queued entries and one request in flight
    lat         = 1;
    instr_ready = 1'b0;
    apply_reset();
    repeat (3) tick();
    #1;
    check_output("pre_reset_instr_valid", 32'(instr_valid), 32'd1);
    check_output("pre_reset_req_valid", 32'(imem_req_valid), 32'd1);
    #1;
    rst             = 1'b0;
    imem_resp_valid = 1'b0;
    mem_q.delete();
    #1;
    check_output("async_req_valid", 32'(imem_req_valid), 32'd0);
    check_output("async_instr_valid", 32'(instr_valid), 32'd0);
    check_output("async_instr_out", instr_out, 32'h0);
    check_output("async_instr_pc", instr_pc, 32'h0);
    apply_reset();
    instr_ready = 1'b1;
    #1;
    check_output("restart_req_valid", 32'(imem_req_valid), 32'd1);
    check_output("restart_req_addr", imem_req_addr, 32'hBFC0_0000);
    repeat (2) tick();
    #1;
    check_output("restart_instr_valid", 32'(instr_valid), 32'd1);
    check_output("restart_instr_pc", instr_pc, 32'hBFC0_0000);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
